// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the sizing rule for the bit counter.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must hold the value WIDTH itself without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// 1-bit full subtractor x - y - bin, built from two half subtractors and an OR,
// matching the structure of the adder datapath.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d_hs1;
    logic b_hs1;
    logic b_hs2;

    half_subtractor u_hs1 (
        .x    (x),
        .y    (y),
        .d    (d_hs1),
        .bout (b_hs1)
    );

    // Second stage subtracts the incoming borrow from the first difference.
    half_subtractor u_hs2 (
        .x    (d_hs1),
        .y    (bin),
        .d    (d),
        .bout (b_hs2)
    );

    assign bout = b_hs1 | b_hs2;

endmodule

// File: rtl/half_subtractor.sv
// 1-bit half subtractor: x - y with difference and borrow-out.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bout
);

    assign d    = x ^ y;
    assign bout = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB first through one
// full-subtractor cell and a registered borrow, with a start/done handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   sa_q,     sa_d;
    logic [WIDTH-1:0]   sb_q,     sb_d;
    logic [WIDTH-1:0]   res_q,    res_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   diff_q,   diff_d;
    logic               bout_q,   bout_d;

    logic               cell_d;
    logic               cell_bout;
    logic [WIDTH-1:0]   res_shift;
    logic               last_bit;

    full_subtractor u_cell (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Each new difference bit enters at the MSB so that after WIDTH shifts
    // the LSB computed first has reached bit 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shift = cell_d;
        end else begin : g_res_wn
            assign res_shift = {cell_d, res_q[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // NOTE: every _d signal is given its hold value before the case so no
    // path through the block leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    sa_d     = a;
                    sb_d     = b;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_BUSY;
                end
            end

            ST_BUSY: begin
                sa_d     = sa_q >> 1;
                sb_d     = sb_q >> 1;
                res_d    = res_shift;
                borrow_d = cell_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    // Visible result is only updated once the final bit is in.
                    diff_d  = res_shift;
                    bout_d  = cell_bout;
                    state_d = ST_DONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    // The operand/result shift registers are reset along with the rest so no
    // X can ever reach the cell, even though they are reloaded before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy  = (state_q == ST_BUSY);
    assign done  = (state_q == ST_DONE);
    assign diff  = diff_q;
    assign bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus randomized
// operands compared against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_diff;
    logic         exp_bout;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    function automatic logic [W-1:0] model_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = int'(x) - int'(y);
        if (r < 0) r = r + (1 << W);
        return W'(r);
    endfunction

    function automatic logic model_bout(input logic [W-1:0] x, input logic [W-1:0] y);
        return int'(x) < int'(y);
    endfunction

    // Starts an operation at the current negedge (block must be ready) and
    // steps through the busy cycles to the done cycle; optionally pulses a
    // stray start in cycle pulse_cyc. Returns at the negedge of the done cycle.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input string tag,
                         input int pulse_cyc, input logic [W-1:0] pa, input logic [W-1:0] pb);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        for (int c = 1; c <= W; c++) begin
            @(negedge clk);
            start = (c == pulse_cyc);
            a     = (c == pulse_cyc) ? pa : W'($urandom);
            b     = (c == pulse_cyc) ? pb : W'($urandom);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || ready !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_phase cycle %0d: busy=%b done=%b ready=%b, required 1 0 0",
                         tag, c, busy, done, ready);
            end
            checks++;
            if (diff !== exp_diff || bout !== exp_bout) begin
                errors++;
                $display("FAIL %s held_during_busy cycle %0d: diff=%h bout=%b, required %h %b",
                         tag, c, diff, bout, exp_diff, exp_bout);
            end
        end
        @(negedge clk);
        start    = 1'b0;
        exp_diff = model_diff(ta, tb_v);
        exp_bout = model_bout(ta, tb_v);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL %s done_cycle: done=%b busy=%b ready=%b, required 1 0 1",
                     tag, done, busy, ready);
        end
        checks++;
        if (diff !== exp_diff || bout !== exp_bout) begin
            errors++;
            $display("FAIL %s result a=%h b=%h: diff=%h bout=%b, required %h %b",
                     tag, ta, tb_v, diff, bout, exp_diff, exp_bout);
        end
    endtask

    // One cycle with no start: block must be idle and still hold the result.
    task automatic idle_check(input string tag);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle: done=%b busy=%b ready=%b, required 0 0 1", tag, done, busy, ready);
        end
        checks++;
        if (diff !== exp_diff || bout !== exp_bout) begin
            errors++;
            $display("FAIL %s held_after_done: diff=%h bout=%b, required %h %b",
                     tag, diff, bout, exp_diff, exp_bout);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) begin
            @(negedge clk);
            start = 1'b1;
            a     = W'($urandom);
            b     = W'($urandom);
            checks++;
            if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
                errors++;
                $display("FAIL reset_values: ready=%b busy=%b done=%b diff=%h bout=%b, required 1 0 0 00 0",
                         ready, busy, done, diff, bout);
            end
        end
        rst      = 1'b0;
        exp_diff = '0;
        exp_bout = 1'b0;
        idle_check("reset_release");
    endtask

    task automatic test_basic();
        do_op(8'h5A, 8'h23, "basic_5a_23", 0, '0, '0);
        idle_check("basic_5a_23");
        idle_check("basic_5a_23_again");
        do_op(8'h23, 8'h5A, "basic_23_5a", 0, '0, '0);
        idle_check("basic_23_5a");
    endtask

    task automatic test_borrow_ripple();
        do_op(8'h00, 8'h01, "ripple_00_01", 0, '0, '0);
        idle_check("ripple_00_01");
        do_op(8'hFF, 8'h00, "ripple_ff_00", 0, '0, '0);
        idle_check("ripple_ff_00");
    endtask

    task automatic test_ignore_start();
        do_op(8'hA5, 8'hA5, "ignore_start", 4, 8'h01, 8'h02);
        idle_check("ignore_start");
        idle_check("ignore_start_no_second_op");
    endtask

    task automatic test_abort();
        do_op(8'hC3, 8'h12, "abort_pre", 0, '0, '0);
        idle_check("abort_pre");
        start = 1'b1;
        a     = 8'h5A;
        b     = 8'h23;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
            if (c == 4) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (diff !== '0 || bout !== 1'b0 || done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: diff=%h bout=%b done=%b ready=%b busy=%b, required 00 0 0 1 0",
                     diff, bout, done, ready, busy);
        end
        exp_diff = '0;
        exp_bout = 1'b0;
        for (int c = 0; c < W + 3; c++) idle_check("abort_no_done");
        do_op(8'h10, 8'h01, "abort_restart", 0, '0, '0);
        checks++;
        if (diff !== 8'h0F) begin
            errors++;
            $display("FAIL abort_restart_value: diff=%h, required 0f", diff);
        end
        idle_check("abort_restart");
    endtask

    task automatic test_back_to_back();
        do_op(8'h80, 8'h01, "b2b_first", 0, '0, '0);
        do_op(8'h01, 8'h80, "b2b_second", 0, '0, '0);
        idle_check("b2b_second");
    endtask

    task automatic test_random();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: ra = '0;
                2: rb = '1;
                default: ;
            endcase
            do_op(ra, rb, $sformatf("random_%0d", i), 0, '0, '0);
            if ($urandom_range(0, 1) == 1) idle_check($sformatf("random_%0d", i));
        end
        idle_check("random_end");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_ripple();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor: the subtraction counterpart of the team's combinational full-adder datapath. It computes A − B one bit per clock, LSB first, through a 1-bit full-subtractor cell and a registered borrow. It uses a start/done handshake so a controller can time-share one cell across WIDTH-bit operands. Area-lean arithmetic for control paths where latency is not critical.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 1.

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous reset, active-high
start  input   1      request; sampled only when ready=1
a      input   WIDTH  minuend; captured on accepted start
b      input   WIDTH  subtrahend; captured on accepted start
ready  output  1      block can accept start this cycle
busy   output  1      subtraction in progress
done   output  1      one-cycle pulse: diff/bout valid
diff   output  WIDTH  (a − b) mod 2^WIDTH; held until next accepted start
bout   output  1      final borrow; 1 iff a < b (unsigned); held with diff

Behaviour:
- One clock; reset is synchronous and active-high. While rst=1 at a rising edge: state=IDLE, ready=1, busy=0, done=0, diff=0, bout=0, borrow=0, counter=0.
- States: IDLE, BUSY, DONE. Encoding is 2-bit.
- IDLE: ready=1, busy=0. On start=1, capture a and b into shift registers sa/sb, clear borrow and counter, then go to BUSY.
- BUSY: ready=0, busy=1. Each cycle:
  - d = sa[0] ^ sb[0] ^ borrow
  - borrow_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow)
  - d shifts into the result register from the MSB end; sa and sb shift right; counter increments.
  - After the WIDTH-th shift, go to DONE.
- DONE: lasts exactly one cycle. done=1, busy=0, ready=1, diff holds the full result, bout=borrow. A start in this cycle is accepted, with the same capture as IDLE, and moves to BUSY. Otherwise return to IDLE.
- diff and bout change only on the transition into DONE and on reset. The partial result is internal; diff does not show intermediate values during BUSY.
- Latency: start sampled high at the end of cycle 0 gives busy=1 in cycles 1..WIDTH and done=1 in cycle WIDTH+1. Throughput is one result per WIDTH+1 cycles with back-to-back starts.
- start while busy=1 is ignored and has no side effects. a and b are don't-care outside the capture cycle.
- Reset mid-operation: abort immediately. Outputs take reset values, no done pulse occurs, and ready=1 in the cycle after reset deasserts.
- The counter is wide enough for WIDTH with no wrap. WIDTH=1 degenerates to one BUSY cycle.
- X-safety: no output may depend on uncaptured a/b.

Decomposition:
- Shared package/include holds:
  - state encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2
  - counter width, computed as clog2(WIDTH+1)
- One natural sub-module: full_subtractor (combinational, 1-bit; inputs x, y, bin; outputs d, bout), built from two half_subtractor cells plus an OR, mirroring the team's adder structure. The top level holds the FSM, shift registers, borrow flop and counter.

Test Plan:
(all WIDTH=8; "cycle" counted from the cycle in which start is sampled)
1. a=0x5A, b=0x23, start in cycle 0 -> busy cycles 1-8; done=1 only in cycle 9; diff=0x37, bout=0; both held afterwards.
2. a=0x23, b=0x5A -> diff=0xC9, bout=1.
3. a=0x00, b=0x01 (full borrow ripple) -> diff=0xFF, bout=1. Then a=0xFF, b=0x00 -> diff=0xFF, bout=0.
4. a=0xA5, b=0xA5 -> diff=0x00, bout=0. Then start pulsed in cycle 4 with a=0x01, b=0x02 -> ignored; result of the first operation is unchanged.
5. rst=1 in cycle 4 of an operation -> cycle 5: diff=0, bout=0, done=0, ready=1, busy=0, and no done pulse follows. Then a new start with a=0x10, b=0x01 -> diff=0x0F at its cycle 9.
6. Back-to-back: start with (0x80, 0x01); start again in its done cycle with (0x01, 0x80) -> first done diff=0x7F, bout=0; second done 9 cycles later with diff=0x81, bout=1.
